// File: rtl/fsab_burst_master_pkg.sv
// fsab_burst_master_pkg: shared FSAB widths, mode encodings, credit defaults and beat types.
package fsab_burst_master_pkg;
    localparam int FSAB_ADDR_HI         = 30;
    localparam int FSAB_LEN_HI          = 3;
    localparam int FSAB_LEN_MAX         = 8;
    localparam int FSAB_DATA_HI         = 63;
    localparam int FSAB_MASK_HI         = 7;
    localparam int FSAB_DID_HI          = 3;
    localparam int FSAB_CREDITS_HI      = 2;
    localparam int FSAB_INITIAL_CREDITS = 4;
    localparam logic FSAB_READ  = 1'b0;
    localparam logic FSAB_WRITE = 1'b1;

    typedef logic [FSAB_ADDR_HI:0]    addr_t;
    typedef logic [FSAB_LEN_HI:0]     len_t;
    typedef logic [FSAB_DATA_HI:0]    data_t;
    typedef logic [FSAB_MASK_HI:0]    mask_t;
    typedef logic [FSAB_DID_HI:0]     did_t;
    typedef logic [FSAB_CREDITS_HI:0] cred_t;

    typedef enum logic {IDLE, WR} state_e;

    typedef struct packed {
        logic  valid;
        logic  mode;
        did_t  did;
        did_t  subdid;
        addr_t addr;
        len_t  len;
        data_t data;
        mask_t mask;
    } beat_t;
endpackage

// File: rtl/fsab_burst_master_if.sv
// fsab_burst_master_if: local command/write/read ports plus the fsabo/fsabi bus of one FSAB master.
interface fsab_burst_master_if;
    import fsab_burst_master_pkg::*;
    logic  cmd_valid, cmd_ready, cmd_write;
    addr_t cmd_addr;
    len_t  cmd_len;
    did_t  cmd_subdid;
    logic  wd_valid, wd_ready;
    data_t wd_data;
    mask_t wd_mask;
    logic  rd_valid, rd_last, busy;
    data_t rd_data;
    did_t  rd_subdid;
    logic  fsabo_valid, fsabo_mode, fsabo_credit;
    did_t  fsabo_did, fsabo_subdid;
    addr_t fsabo_addr;
    len_t  fsabo_len;
    data_t fsabo_data;
    mask_t fsabo_mask;
    logic  fsabi_valid;
    did_t  fsabi_did, fsabi_subdid;
    data_t fsabi_data;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_subdid, wd_valid, wd_data, wd_mask,
               fsabo_credit, fsabi_valid, fsabi_did, fsabi_subdid, fsabi_data,
        output cmd_ready, wd_ready, rd_valid, rd_data, rd_subdid, rd_last, busy,
               fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len,
               fsabo_data, fsabo_mask
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_subdid, wd_valid, wd_data, wd_mask,
               fsabo_credit, fsabi_valid, fsabi_did, fsabi_subdid, fsabi_data,
        input  cmd_ready, wd_ready, rd_valid, rd_data, rd_subdid, rd_last, busy,
               fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len,
               fsabo_data, fsabo_mask
    );
endinterface

// File: rtl/fsab_credit_counter.sv
// fsab_credit_counter: FSAB request credit counter, reset to and capped at MAX.
// Defining FSAB_BURST_MASTER_CHECK_EN adds a simulation check for credits returned past MAX.
module fsab_credit_counter
    import fsab_burst_master_pkg::*;
#(
    parameter int MAX = FSAB_INITIAL_CREDITS
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  logic  dec,
    output cred_t count,
    output logic  nonzero
);
    localparam cred_t MAX_V = cred_t'(MAX);

    cred_t count_q, count_d;

    always_comb count_d = (inc && !dec && count_q != MAX_V) ? count_q + cred_t'(1) :
                          (dec && !inc) ? count_q - cred_t'(1) : count_q;

    always_ff @(posedge clk) begin
        if (rst) count_q <= MAX_V;
        else     count_q <= count_d;
    end

    assign count   = count_q;
    assign nonzero = count_q != '0;

`ifdef FSAB_BURST_MASTER_CHECK_EN
    always @(posedge clk)
        if (!rst && inc && !dec && count_q == MAX_V) $error("credit returned past MAX");
`else
`endif
endmodule

// File: rtl/fsab_burst_master.sv
// fsab_burst_master: turns local read/write commands into FSAB request beats and filters returns by DID.
// Defining FSAB_BURST_MASTER_CHECK_EN adds simulation-only protocol checks.
module fsab_burst_master
    import fsab_burst_master_pkg::*;
#(
    parameter int DID         = 0,
    parameter int MAX_CREDITS = FSAB_INITIAL_CREDITS
) (
    input logic clk,
    input logic rst,
    fsab_burst_master_if.master bus
);
    localparam did_t  DID_V = did_t'(DID);
    localparam cred_t MAX_V = cred_t'(MAX_CREDITS);

    state_e state_q, state_d;
    beat_t  beat_q, beat_d;
    len_t   wr_rem_q, wr_rem_d, rd_rem_q, rd_rem_d;
    logic   rd_pend_q, rd_pend_d;
    logic   rd_valid_q, rd_last_q;
    data_t  rd_data_q;
    did_t   rd_subdid_q;
    cred_t  credits;
    logic   has_credit, cmd_hs, wd_hs, ret;

    assign bus.cmd_ready = !rst && state_q == IDLE && has_credit && (bus.cmd_write || !rd_pend_q);
    assign bus.wd_ready  = !rst && state_q == WR;
    assign bus.busy      = !rst && (state_q == WR || rd_pend_q || credits != MAX_V);
    assign cmd_hs = bus.cmd_valid && bus.cmd_ready;
    assign wd_hs  = bus.wd_valid && bus.wd_ready;
    assign ret    = bus.fsabi_valid && bus.fsabi_did == DID_V && rd_pend_q;

    fsab_credit_counter #(.MAX(MAX_CREDITS)) u_credits (
        .clk(clk), .rst(rst), .inc(bus.fsabo_credit), .dec(cmd_hs),
        .count(credits), .nonzero(has_credit)
    );

    // Header fields only change on a command, so they hold across write-data gaps.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        beat_d.valid = 1'b0;
        wr_rem_d  = wr_rem_q;
        rd_rem_d  = rd_rem_q;
        rd_pend_d = rd_pend_q;
        if (cmd_hs) begin
            beat_d.valid  = !bus.cmd_write;
            beat_d.mode   = bus.cmd_write ? FSAB_WRITE : FSAB_READ;
            beat_d.did    = DID_V;
            beat_d.subdid = bus.cmd_subdid;
            beat_d.addr   = bus.cmd_addr;
            beat_d.len    = bus.cmd_len;
            state_d   = bus.cmd_write ? WR : IDLE;
            wr_rem_d  = bus.cmd_write ? bus.cmd_len : wr_rem_q;
            rd_rem_d  = bus.cmd_write ? rd_rem_q : bus.cmd_len;
            rd_pend_d = rd_pend_q || !bus.cmd_write;
        end
        if (wd_hs) begin
            beat_d.valid = 1'b1;
            beat_d.data  = bus.wd_data;
            beat_d.mask  = bus.wd_mask;
            wr_rem_d = wr_rem_q - len_t'(1);
            state_d  = wr_rem_q == len_t'(1) ? IDLE : WR;
        end
        if (ret) begin
            rd_rem_d  = rd_rem_q - len_t'(1);
            rd_pend_d = rd_rem_q != len_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            wr_rem_q    <= '0;
            rd_rem_q    <= '0;
            rd_pend_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
            rd_subdid_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wr_rem_q    <= wr_rem_d;
            rd_rem_q    <= rd_rem_d;
            rd_pend_q   <= rd_pend_d;
            rd_valid_q  <= ret;
            rd_last_q   <= ret && rd_rem_q == len_t'(1);
            rd_data_q   <= bus.fsabi_data;
            rd_subdid_q <= bus.fsabi_subdid;
        end
    end

    assign bus.fsabo_valid  = beat_q.valid;
    assign bus.fsabo_mode   = beat_q.mode;
    assign bus.fsabo_did    = beat_q.did;
    assign bus.fsabo_subdid = beat_q.subdid;
    assign bus.fsabo_addr   = beat_q.addr;
    assign bus.fsabo_len    = beat_q.len;
    assign bus.fsabo_data   = beat_q.data;
    assign bus.fsabo_mask   = beat_q.mask;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_last      = rd_last_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_subdid    = rd_subdid_q;

`ifdef FSAB_BURST_MASTER_CHECK_EN
    always @(posedge clk) begin
        if (!rst && cmd_hs && (bus.cmd_len == '0 || int'(bus.cmd_len) > FSAB_LEN_MAX))
            $error("command accepted with illegal length %0d", bus.cmd_len);
        if (!rst && bus.fsabi_valid && bus.fsabi_did == DID_V && !rd_pend_q)
            $error("return beat for this DID with no read pending");
    end
`else
`endif
endmodule

// File: tb/tb_fsab_burst_master.sv
// tb_fsab_burst_master: directed table, hand sequences and random traffic against a transaction-level model.
module tb_fsab_burst_master;
    import fsab_burst_master_pkg::*;

    localparam int DID  = 0;
    localparam int MAXC = 4;

    typedef struct {
        bit cv, cw;
        int len;
        bit wv, cr, fv, doff;
        bit e_ready, e_fv, e_rv, e_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;

    int    m_cr, m_wr_left, m_rd_left;
    bit    m_wr;
    logic  e_mode;
    did_t  e_sub;
    addr_t e_addr;
    len_t  e_len;
    data_t e_data;
    mask_t e_mask;
    vec_t  tbl[15];
    vec_t  nov;

    fsab_burst_master_if bus();

    fsab_burst_master #(.DID(DID), .MAX_CREDITS(MAXC)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_subdid = '0;
        bus.wd_valid = 0; bus.wd_data = '0; bus.wd_mask = '0; bus.fsabo_credit = 0;
        bus.fsabi_valid = 0; bus.fsabi_did = '0; bus.fsabi_subdid = '0; bus.fsabi_data = '0;
    endtask

    // One clock: check handshake outputs, advance the model, check registered outputs.
    task automatic step(input bit t, input vec_t v);
        bit r, acc, wb, ret, e_fv, e_last, e_rdy;
        data_t rdat;
        did_t  rsub;
        #1;
        r = rst;
        e_rdy = 0;
        if (r) begin
            chk("rst_cmd_ready", bus.cmd_ready, 0);
            chk("rst_wd_ready", bus.wd_ready, 0);
            chk("rst_busy", bus.busy, 0);
        end else begin
            e_rdy = !m_wr && m_cr > 0 && (bus.cmd_write || m_rd_left == 0);
            chk("cmd_ready", bus.cmd_ready, e_rdy);
            chk("wd_ready", bus.wd_ready, m_wr);
            chk("busy", bus.busy, m_wr || m_rd_left > 0 || m_cr < MAXC);
            if (t) chk("tbl_ready", bus.cmd_ready, v.e_ready);
        end
        acc  = !r && bus.cmd_valid && e_rdy;
        wb   = !r && m_wr && bus.wd_valid;
        ret  = !r && bus.fsabi_valid && bus.fsabi_did == did_t'(DID) && m_rd_left > 0;
        e_last = ret && m_rd_left == 1;
        e_fv = (acc && !bus.cmd_write) || wb;
        rdat = bus.fsabi_data;
        rsub = bus.fsabi_subdid;
        if (r) begin
            m_cr = MAXC; m_wr = 0; m_wr_left = 0; m_rd_left = 0;
            e_mode = 0; e_sub = '0; e_addr = '0; e_len = '0; e_data = '0; e_mask = '0;
        end else begin
            if (acc) begin
                e_mode = bus.cmd_write; e_sub = bus.cmd_subdid; e_addr = bus.cmd_addr; e_len = bus.cmd_len;
                if (bus.cmd_write) begin m_wr = 1; m_wr_left = int'(bus.cmd_len); end
                else m_rd_left = int'(bus.cmd_len);
            end
            if (wb) begin
                e_data = bus.wd_data; e_mask = bus.wd_mask;
                m_wr_left--;
                if (m_wr_left == 0) m_wr = 0;
            end
            if (ret) m_rd_left--;
            m_cr += int'(bus.fsabo_credit) - int'(acc);
            if (m_cr > MAXC) m_cr = MAXC;
        end
        @(posedge clk);
        #1;
        chk("fsabo_valid", bus.fsabo_valid, e_fv);
        chk("rd_valid", bus.rd_valid, ret);
        chk("rd_last", bus.rd_last, e_last);
        if (e_fv) chk("fsabo_did", bus.fsabo_did, did_t'(DID));
        if (e_fv || m_wr || r) begin
            chk("fsabo_mode", bus.fsabo_mode, e_mode);
            chk("fsabo_subdid", bus.fsabo_subdid, e_sub);
            chk("fsabo_addr", bus.fsabo_addr, e_addr);
            chk("fsabo_len", bus.fsabo_len, e_len);
        end
        if ((e_fv && e_mode == FSAB_WRITE) || r) begin
            chk("fsabo_data", bus.fsabo_data, e_data);
            chk("fsabo_mask", bus.fsabo_mask, e_mask);
        end
        if (ret) begin
            chk("rd_data", bus.rd_data, rdat);
            chk("rd_subdid", bus.rd_subdid, rsub);
        end
        if (t) begin
            chk("tbl_fv", bus.fsabo_valid, v.e_fv);
            chk("tbl_rv", bus.rd_valid, v.e_rv);
            chk("tbl_last", bus.rd_last, v.e_last);
        end
    endtask

    task automatic cyc(input bit r, input bit cv, input bit cw, input bit wv, input bit cr, input int len);
        idle_in();
        rst = r;
        bus.cmd_valid = cv; bus.cmd_write = cw; bus.cmd_len = len_t'(len);
        bus.cmd_addr = addr_t'($urandom); bus.cmd_subdid = did_t'($urandom);
        bus.wd_valid = wv; bus.wd_data = {$urandom, $urandom}; bus.wd_mask = mask_t'($urandom);
        bus.fsabo_credit = cr;
        step(0, nov);
    endtask

    initial begin
        //          cv cw len wv cr fv doff rdy fv rv last
        tbl[0]  = '{1, 0, 4, 0, 0, 0, 0,  1,  1, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 1, 0, 0,  0,  0, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 0, 1, 0,  0,  0, 1, 0};
        tbl[3]  = '{0, 0, 1, 0, 0, 1, 1,  0,  0, 0, 0};
        tbl[4]  = '{0, 0, 1, 0, 0, 1, 0,  0,  0, 1, 0};
        tbl[5]  = '{0, 0, 1, 0, 0, 1, 0,  0,  0, 1, 0};
        tbl[6]  = '{1, 0, 2, 0, 0, 1, 0,  0,  0, 1, 1};
        tbl[7]  = '{1, 0, 1, 0, 0, 0, 0,  1,  1, 0, 0};
        tbl[8]  = '{1, 1, 3, 0, 0, 0, 0,  1,  0, 0, 0};
        tbl[9]  = '{0, 0, 1, 1, 0, 1, 0,  0,  1, 1, 1};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 0,  0,  0, 0, 0};
        tbl[11] = '{0, 0, 1, 1, 0, 0, 0,  0,  1, 0, 0};
        tbl[12] = '{0, 0, 1, 1, 0, 0, 0,  0,  1, 0, 0};
        tbl[13] = '{1, 1, 1, 0, 0, 0, 0,  1,  0, 0, 0};
        tbl[14] = '{0, 0, 1, 1, 0, 0, 0,  0,  1, 0, 0};

        idle_in();
        rst = 1;
        step(0, nov);
        step(0, nov);
        rst = 0;

        for (int i = 0; i < 15; i++) begin
            idle_in();
            bus.cmd_valid = tbl[i].cv; bus.cmd_write = tbl[i].cw; bus.cmd_len = len_t'(tbl[i].len);
            bus.cmd_addr = addr_t'(32'h100 + (tbl[i].cw ? 32'h100 : 32'h0) + i);
            bus.cmd_subdid = did_t'(i);
            bus.wd_valid = tbl[i].wv; bus.wd_data = {32'hd0d0, 32'(i)}; bus.wd_mask = mask_t'(i);
            bus.fsabo_credit = tbl[i].cr;
            bus.fsabi_valid = tbl[i].fv; bus.fsabi_did = did_t'(DID + int'(tbl[i].doff));
            bus.fsabi_subdid = did_t'(i + 3); bus.fsabi_data = 64'hbeef0000 + 64'(i);
            step(1, tbl[i]);
        end

        repeat (3) cyc(0, 0, 0, 0, 1, 1);
        for (int k = 0; k < MAXC; k++) begin
            cyc(0, 1, 1, 0, 0, 1);
            cyc(0, 0, 1, 1, 0, 1);
        end
        chk("no_credit_block", bus.cmd_ready, 0);
        cyc(0, 1, 1, 0, 1, 1);
        chk("credit_reopen", bus.cmd_ready, 1);
        cyc(0, 1, 1, 0, 0, 1);
        cyc(0, 0, 1, 1, 0, 1);
        chk("one_more_only", bus.cmd_ready, 0);
        cyc(0, 0, 1, 0, 1, 1);
        cyc(0, 1, 1, 0, 1, 1);
        cyc(0, 0, 1, 1, 0, 1);
        chk("same_cycle_hold", bus.cmd_ready, 1);

        cyc(0, 1, 1, 0, 0, 4);
        cyc(0, 0, 1, 1, 0, 4);
        cyc(0, 0, 1, 1, 0, 4);
        cyc(1, 0, 1, 1, 0, 4);
        chk("rst_mid_fv", bus.fsabo_valid, 0);
        cyc(0, 0, 1, 1, 0, 4);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_fv2", bus.fsabo_valid, 0);

        for (int n = 0; n < 3000; n++) begin
            idle_in();
            rst = $urandom_range(0, 299) == 0;
            bus.cmd_valid = $urandom_range(0, 2) == 0;
            bus.cmd_write = 1'($urandom_range(0, 1));
            bus.cmd_len = len_t'($urandom_range(1, FSAB_LEN_MAX));
            bus.cmd_addr = addr_t'($urandom);
            bus.cmd_subdid = did_t'($urandom);
            bus.wd_valid = $urandom_range(0, 3) != 0;
            bus.wd_data = {$urandom, $urandom};
            bus.wd_mask = mask_t'($urandom);
            bus.fsabo_credit = m_cr < MAXC && $urandom_range(0, 2) == 0;
            if (m_rd_left > 0 && $urandom_range(0, 1) == 1) begin
                bus.fsabi_valid = 1;
                bus.fsabi_did = did_t'(DID + $urandom_range(0, 1));
            end else if ($urandom_range(0, 3) == 0) begin
                bus.fsabi_valid = 1;
                bus.fsabi_did = did_t'(DID + $urandom_range(1, 2));
            end
            bus.fsabi_subdid = did_t'($urandom);
            bus.fsabi_data = {$urandom, $urandom};
            step(0, nov);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
